// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32 control path.
// Select and ALU-op codes match the datapath mux encodings one-to-one.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_ILLEGAL
  } state_t;

  typedef enum logic {CLS_ADD, CLS_RTYPE} alu_cls_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [2:0] F3_W     = 3'b010;
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [6:0] F7_ADD   = 7'b0000000;
  localparam logic [6:0] F7_SUB   = 7'b0100000;

  localparam logic [1:0] ASRC_PC    = 2'b00;
  localparam logic [1:0] ASRC_RS1   = 2'b01;
  localparam logic [1:0] BSRC_RS2   = 2'b00;
  localparam logic [1:0] BSRC_FOUR  = 2'b01;
  localparam logic [1:0] BSRC_IMM   = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;

  typedef struct packed {
    logic       mem_write;
    logic       reg_write;
    logic       ir_write;
    logic       pc_write;
    logic       iord;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       instr_done;
  } ctrl_t;

  // Any field mismatch on a known opcode is treated the same as an unknown opcode.
  function automatic state_t decode_next(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [6:0] f7);
    case (op)
      OP_LOAD, OP_STORE: return (f3 == F3_W) ? S_MEMADR : S_ILLEGAL;
      OP_RTYPE: return (f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) ? S_EXECR : S_ILLEGAL;
      OP_IMM:   return (f3 == F3_ADD) ? S_EXECI : S_ILLEGAL;
      default:  return S_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select: only register-register execute can ask for subtract.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    if (cls == CLS_RTYPE && funct3 == F3_ADD && funct7 == F7_SUB) alu_control = ALU_SUB;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32 core: sequences the datapath one state
// per cycle, counts retired instructions and latches a sticky illegal flag.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  output logic             mem_write,
  output logic             reg_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             instruction_or_data,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           state;
  state_t           dec_next;
  ctrl_t            c;
  alu_cls_t         cls;
  logic [2:0]       alu_op;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt;
  logic             unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};
  assign dec_next     = decode_next(opcode, funct3, funct7);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:   state <= S_DECODE;
        S_DECODE: begin
          state <= dec_next;
          if (dec_next == S_ILLEGAL) illegal_q <= 1'b1;
        end
        S_MEMADR:  state <= (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: state <= S_MEMWB;
        S_EXECR, S_EXECI: state <= S_ALUWB;
        S_MEMWB, S_MEMWRITE, S_ALUWB: begin
          state <= S_FETCH;
          cnt   <= cnt + CNT_W'(1);
        end
        S_ILLEGAL: state <= S_ILLEGAL;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // Moore decode; gating with reset kills strobes without waiting for an edge.
  always_comb begin
    c            = '0;
    c.alu_src_a  = ASRC_PC;
    c.alu_src_b  = BSRC_RS2;
    c.result_src = RES_ALUOUT;
    case (state)
      S_FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = BSRC_FOUR; end
      S_DECODE:   c.pc_write = 1'b1;
      S_MEMADR:   begin c.alu_src_a = ASRC_RS1; c.alu_src_b = BSRC_IMM; end
      S_MEMREAD:  c.iord = 1'b1;
      S_MEMWB:    begin c.result_src = RES_RDATA; c.reg_write = 1'b1; c.instr_done = 1'b1; end
      S_MEMWRITE: begin c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; end
      S_EXECR:    c.alu_src_a = ASRC_RS1;
      S_EXECI:    begin c.alu_src_a = ASRC_RS1; c.alu_src_b = BSRC_IMM; end
      S_ALUWB:    begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
      default:    ;
    endcase
    if (reset) c = '0;
  end

  assign cls = (state == S_EXECR) ? CLS_RTYPE : CLS_ADD;

  alu_decoder u_alu_dec (
    .cls         (cls),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (alu_op)
  );

  assign mem_write           = c.mem_write;
  assign reg_write           = c.reg_write;
  assign ir_write            = c.ir_write;
  assign pc_write            = c.pc_write;
  assign instruction_or_data = c.iord;
  assign result_src          = c.result_src;
  assign alu_src_a           = c.alu_src_a;
  assign alu_src_b           = c.alu_src_b;
  assign instr_done          = c.instr_done;
  assign alu_control         = reset ? ALU_ADD : alu_op;
  assign illegal             = illegal_q;
  assign retired             = cnt;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each supported instruction,
// illegal encodings and a mid-instruction reset against hand-written vectors.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_write, reg_write, ir_write, pc_write, instruction_or_data;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  alu_control;
  logic        instr_done, illegal;
  logic [31:0] retired;
  int          total = 0;
  int          bad = 0;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .instr               (instr),
    .mem_write           (mem_write),
    .reg_write           (reg_write),
    .ir_write            (ir_write),
    .pc_write            (pc_write),
    .instruction_or_data (instruction_or_data),
    .result_src          (result_src),
    .alu_src_a           (alu_src_a),
    .alu_src_b           (alu_src_b),
    .alu_control         (alu_control),
    .instr_done          (instr_done),
    .illegal             (illegal),
    .retired             (retired)
  );

  always #5 clk = ~clk;

  // {mem_write, reg_write, ir_write, pc_write, iord, result_src, a, b, alu_control, instr_done, illegal}
  logic [15:0] obs;
  assign obs = {mem_write, reg_write, ir_write, pc_write, instruction_or_data,
                result_src, alu_src_a, alu_src_b, alu_control, instr_done, illegal};

  localparam logic [15:0] E_RST    = 16'h0000;
  localparam logic [15:0] E_FETCH  = {5'b00100, 2'b00, 2'b00, 2'b01, 3'b000, 2'b00};
  localparam logic [15:0] E_DECODE = {5'b00010, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [15:0] E_MEMADR = {5'b00000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00};
  localparam logic [15:0] E_MEMRD  = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [15:0] E_MEMWB  = {5'b01000, 2'b01, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [15:0] E_MEMWR  = {5'b10001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [15:0] E_EXADD  = {5'b00000, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00};
  localparam logic [15:0] E_EXSUB  = {5'b00000, 2'b00, 2'b01, 2'b00, 3'b001, 2'b00};
  localparam logic [15:0] E_EXECI  = {5'b00000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00};
  localparam logic [15:0] E_ALUWB  = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [15:0] E_ILL    = {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01};

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0080A103;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_LWF3 = 32'h00808103;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outs", 32'(obs), 32'(E_RST));
    chk("rst_retired", retired, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_fetch", 32'(obs), 32'(E_FETCH));
  endtask

  initial begin
    instr = I_ADDI;
    do_reset();
    // addi: FETCH, DECODE, EXECI, ALUWB
    nxt(); chk("addi_decode", 32'(obs), 32'(E_DECODE));
    nxt(); chk("addi_execi", 32'(obs), 32'(E_EXECI));
    nxt(); chk("addi_aluwb", 32'(obs), 32'(E_ALUWB));
    chk("addi_ret_before", retired, 32'd0);
    nxt(); chk("addi_ret_after", retired, 32'd1);
    chk("lw_fetch", 32'(obs), 32'(E_FETCH));
    // lw: 5 cycles
    instr = I_LW;
    nxt(); chk("lw_decode", 32'(obs), 32'(E_DECODE));
    nxt(); chk("lw_memadr", 32'(obs), 32'(E_MEMADR));
    nxt(); chk("lw_memread", 32'(obs), 32'(E_MEMRD));
    nxt(); chk("lw_memwb", 32'(obs), 32'(E_MEMWB));
    nxt(); chk("lw_ret", retired, 32'd2);
    chk("sw_fetch", 32'(obs), 32'(E_FETCH));
    // sw: 4 cycles, mem_write only in cycle 4
    instr = I_SW;
    nxt(); chk("sw_decode", 32'(obs), 32'(E_DECODE));
    nxt(); chk("sw_memadr", 32'(obs), 32'(E_MEMADR));
    nxt(); chk("sw_memwrite", 32'(obs), 32'(E_MEMWR));
    nxt(); chk("sw_ret", retired, 32'd3);
    chk("sw_after_fetch", 32'(obs), 32'(E_FETCH));
    // sub then add
    instr = I_SUB;
    nxt(); chk("sub_decode", 32'(obs), 32'(E_DECODE));
    nxt(); chk("sub_execr", 32'(obs), 32'(E_EXSUB));
    nxt(); chk("sub_aluwb", 32'(obs), 32'(E_ALUWB));
    nxt(); chk("sub_ret", retired, 32'd4);
    instr = I_ADD;
    nxt(); chk("add_decode", 32'(obs), 32'(E_DECODE));
    nxt(); chk("add_execr", 32'(obs), 32'(E_EXADD));
    nxt(); chk("add_aluwb", 32'(obs), 32'(E_ALUWB));
    nxt(); chk("add_ret", retired, 32'd5);
    // unknown opcode: ILLEGAL is sticky and silent
    instr = I_BAD;
    nxt(); chk("bad_decode", 32'(obs), 32'(E_DECODE));
    for (int i = 0; i < 3; i++) begin
      nxt(); chk("bad_illegal", 32'(obs), 32'(E_ILL));
      chk("bad_ret", retired, 32'd5);
    end
    instr = I_ADDI;
    nxt(); chk("bad_sticky", 32'(obs), 32'(E_ILL));

    // reset clears illegal; one addi, then reset in the middle of a lw
    do_reset();
    chk("rst_illegal_clr", 32'(illegal), 32'd0);
    repeat (3) nxt();
    nxt(); chk("addi2_ret", retired, 32'd1);
    instr = I_LW;
    nxt(); nxt();
    nxt(); chk("lw2_memread", 32'(obs), 32'(E_MEMRD));
    reset = 1'b1;
    #1;
    chk("midrst_outs", 32'(obs), 32'(E_RST));
    chk("midrst_retired", retired, 32'd0);
    for (int i = 0; i < 2; i++) begin
      nxt(); chk("midrst_hold", 32'(obs), 32'(E_RST));
    end
    reset = 1'b0;
    #1;
    chk("midrst_fetch", 32'(obs), 32'(E_FETCH));
    chk("midrst_ret_after", retired, 32'd0);

    // lw opcode with wrong funct3
    instr = I_LWF3;
    nxt(); chk("lwf3_decode", 32'(obs), 32'(E_DECODE));
    nxt(); chk("lwf3_illegal", 32'(obs), 32'(E_ILL));

    // R-type with unsupported funct7
    instr = I_MUL;
    do_reset();
    nxt(); chk("mul_decode", 32'(obs), 32'(E_DECODE));
    nxt(); chk("mul_illegal", 32'(obs), 32'(E_ILL));
    chk("mul_ret", retired, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
